// File: rtl/sync_fifo_flags_if.sv
// Bus bundle for sync_fifo_flags: producer/consumer requests plus data and status.
// The master modport is the side that drives requests; the slave is the FIFO itself.
`timescale 1ns/1ps
interface sync_fifo_flags_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
);
    logic [WIDTH-1:0]         data_in;
    logic                     wr;
    logic                     rd;
    logic                     flush;
    logic                     clr_err;
    logic [WIDTH-1:0]         data_out;
    logic                     empty;
    logic                     full;
    logic                     almost_empty;
    logic                     almost_full;
    logic [$clog2(DEPTH):0]   count;
    logic                     overflow;
    logic                     underflow;

    modport master (
        output data_in, wr, rd, flush, clr_err,
        input  data_out, empty, full, almost_empty, almost_full, count, overflow, underflow
    );

    modport slave (
        input  data_in, wr, rd, flush, clr_err,
        output data_out, empty, full, almost_empty, almost_full, count, overflow, underflow
    );
endinterface

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with standard or first-word-fall-through read, registered occupancy
// count, programmable almost-full/almost-empty levels, sticky error flags and flush.
`timescale 1ns/1ps
module sync_fifo_flags #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned DEPTH    = 8,
    parameter int unsigned FWFT     = 0,
    parameter int unsigned AF_LEVEL = DEPTH - 2,
    parameter int unsigned AE_LEVEL = 1
) (
    input logic              clk,
    input logic              rst,
    sync_fifo_flags_if.slave fifo_io
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] One    = (AW + 1)'(1);
    localparam logic [AW:0] DepthC = (AW + 1)'(DEPTH);
    localparam logic [AW:0] AfC    = (AW + 1)'(AF_LEVEL);
    localparam logic [AW:0] AeC    = (AW + 1)'(AE_LEVEL);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, count_q, count_d;
    logic             ovf_q, ovf_d, unf_q, unf_d;
    logic             empty_q, full_q, ae_q, af_q;
    logic             do_rd, do_wr;
    logic [AW-1:0]    rd_addr, wr_addr;

    assign do_rd   = fifo_io.rd & ~empty_q;
    assign do_wr   = fifo_io.wr & (~full_q | do_rd);
    assign rd_addr = rd_ptr_q[AW-1:0];
    assign wr_addr = wr_ptr_q[AW-1:0];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        unf_d    = unf_q;
        if (fifo_io.flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_wr) wr_ptr_d = wr_ptr_q + One;
            if (do_rd) rd_ptr_d = rd_ptr_q + One;
            case ({do_wr, do_rd})
                2'b10:   count_d = count_q + One;
                2'b01:   count_d = count_q - One;
                default: count_d = count_q;
            endcase
            // A set condition in the same cycle as clr_err wins.
            if (fifo_io.clr_err) begin
                ovf_d = 1'b0;
                unf_d = 1'b0;
            end
            if (fifo_io.wr && full_q && !do_rd) ovf_d = 1'b1;
            if (fifo_io.rd && empty_q)          unf_d = 1'b1;
        end
    end

    // Flags are registered from count_d so they move on the same edge as count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
            ae_q     <= 1'b1;
            af_q     <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
            empty_q  <= (count_d == '0);
            full_q   <= (count_d == DepthC);
            ae_q     <= (count_d <= AeC);
            af_q     <= (count_d >= AfC);
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr && !fifo_io.flush) mem_q[wr_addr] <= fifo_io.data_in;
    end

    if (FWFT != 0) begin : g_fwft
        assign fifo_io.data_out = mem_q[rd_addr];
    end else begin : g_std
        logic [WIDTH-1:0] dout_q;
        always_ff @(posedge clk or posedge rst) begin
            if (rst)                         dout_q <= '0;
            else if (do_rd && !fifo_io.flush) dout_q <= mem_q[rd_addr];
        end
        assign fifo_io.data_out = dout_q;
    end

    assign fifo_io.empty        = empty_q;
    assign fifo_io.full         = full_q;
    assign fifo_io.almost_empty = ae_q;
    assign fifo_io.almost_full  = af_q;
    assign fifo_io.count        = count_q;
    assign fifo_io.overflow     = ovf_q;
    assign fifo_io.underflow    = unf_q;

    // Wrap-bit pointers must always differ by exactly the occupancy.
    a_count_ptr: assert property (@(posedge clk) disable iff (rst)
        count_q == (wr_ptr_q - rd_ptr_q));
endmodule

// File: tb/tb_sync_fifo_flags.sv
// Scoreboard bench for sync_fifo_flags: a queue-based model predicts every cycle's outputs
// for a standard-mode and an FWFT-mode instance; a monitor compares after each edge.
`timescale 1ns/1ps
module tb_sync_fifo_flags;
    localparam int Depth = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sync_fifo_flags_if #(.WIDTH(8), .DEPTH(Depth)) if_s ();
    sync_fifo_flags_if #(.WIDTH(8), .DEPTH(Depth)) if_f ();

    sync_fifo_flags #(.WIDTH(8), .DEPTH(Depth), .FWFT(0)) u_std (
        .clk     (clk),
        .rst     (rst),
        .fifo_io (if_s)
    );
    sync_fifo_flags #(.WIDTH(8), .DEPTH(Depth), .FWFT(1)) u_fwft (
        .clk     (clk),
        .rst     (rst),
        .fifo_io (if_f)
    );

    typedef struct {
        int         cnt;
        bit         ovf;
        bit         unf;
        bit         chk_data;
        logic [7:0] data;
    } exp_t;

    exp_t       exp_q [$];
    logic [7:0] ref_q [$];
    bit         m_ovf, m_unf;
    logic [7:0] m_dout;
    bit         mode;  // 0: standard instance, 1: FWFT instance
    int         n_cmp = 0;
    int         n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_outputs(input int cnt, input bit ovf, input bit unf,
                                 input bit chk_data, input logic [7:0] data);
        logic [3:0] a_cnt;
        logic       a_e, a_f, a_ae, a_af, a_ovf, a_unf;
        logic [7:0] a_d;
        if (mode == 1'b0) begin
            a_cnt = if_s.count; a_e = if_s.empty; a_f = if_s.full; a_ae = if_s.almost_empty;
            a_af = if_s.almost_full; a_ovf = if_s.overflow; a_unf = if_s.underflow;
            a_d = if_s.data_out;
        end else begin
            a_cnt = if_f.count; a_e = if_f.empty; a_f = if_f.full; a_ae = if_f.almost_empty;
            a_af = if_f.almost_full; a_ovf = if_f.overflow; a_unf = if_f.underflow;
            a_d = if_f.data_out;
        end
        check("count", 32'(a_cnt), 32'(cnt));
        check("empty", 32'(a_e), 32'(cnt == 0));
        check("full", 32'(a_f), 32'(cnt == Depth));
        check("almost_empty", 32'(a_ae), 32'(cnt <= 1));
        check("almost_full", 32'(a_af), 32'(cnt >= Depth - 2));
        check("overflow", 32'(a_ovf), 32'(ovf));
        check("underflow", 32'(a_unf), 32'(unf));
        if (chk_data) check("data_out", 32'(a_d), 32'(data));
    endtask

    // Monitor: one expectation per driven cycle, compared just after the edge it describes.
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check_outputs(e.cnt, e.ovf, e.unf, e.chk_data, e.data);
        end
    end

    task automatic step(input bit w, input bit r, input logic [7:0] d,
                        input bit fl = 1'b0, input bit ce = 1'b0);
        exp_t e;
        int   n;
        bit   pop, push;
        @(negedge clk);
        if (mode == 1'b0) begin
            if_s.wr = w; if_s.rd = r; if_s.data_in = d; if_s.flush = fl; if_s.clr_err = ce;
        end else begin
            if_f.wr = w; if_f.rd = r; if_f.data_in = d; if_f.flush = fl; if_f.clr_err = ce;
        end
        n = ref_q.size();
        if (fl) begin
            ref_q.delete();
        end else begin
            pop  = r && (n > 0);
            push = w && ((n < Depth) || pop);
            if (ce) begin m_ovf = 1'b0; m_unf = 1'b0; end
            if (w && (n == Depth) && !pop) m_ovf = 1'b1;
            if (r && (n == 0))             m_unf = 1'b1;
            if (pop)  m_dout = ref_q.pop_front();
            if (push) ref_q.push_back(d);
        end
        e.cnt = ref_q.size();
        e.ovf = m_ovf;
        e.unf = m_unf;
        if (mode == 1'b0) begin
            e.chk_data = 1'b1;
            e.data     = m_dout;
        end else begin
            e.chk_data = (ref_q.size() > 0);
            e.data     = e.chk_data ? ref_q[0] : 8'h00;
        end
        exp_q.push_back(e);
    endtask

    // Reset asserted between edges; outputs must reach reset values without a clock.
    task automatic do_reset();
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check_outputs(0, 1'b0, 1'b0, (mode == 1'b0), 8'h00);
        ref_q.delete();
        m_ovf  = 1'b0;
        m_unf  = 1'b0;
        m_dout = 8'h00;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic random_run(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            bit w, r, fl, ce;
            w  = ($urandom_range(0, 9) < 6);
            r  = ($urandom_range(0, 9) < 5);
            fl = ($urandom_range(0, 31) == 0);
            ce = !fl && ($urandom_range(0, 15) == 0);
            step(w, r, 8'($urandom), fl, ce);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        {if_s.wr, if_s.rd, if_s.flush, if_s.clr_err} = '0;
        {if_f.wr, if_f.rd, if_f.flush, if_f.clr_err} = '0;
        if_s.data_in = '0;
        if_f.data_in = '0;
        mode = 1'b0;
        repeat (2) @(negedge clk);

        // Reset, fill, overflow, drain, underflow, clear.
        do_reset();
        for (int i = 0; i < Depth; i++) step(1'b1, 1'b0, 8'(8'h10 + i));
        step(1'b1, 1'b0, 8'hAA);
        for (int i = 0; i < Depth; i++) step(1'b0, 1'b1, 8'h00);
        step(1'b0, 1'b1, 8'h00);
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);

        // Simultaneous write and read at full and at empty.
        for (int i = 0; i < Depth; i++) step(1'b1, 1'b0, 8'(8'h10 + i));
        step(1'b1, 1'b1, 8'h55);
        for (int i = 0; i < Depth; i++) step(1'b0, 1'b1, 8'h00);
        step(1'b1, 1'b1, 8'h66);
        step(1'b0, 1'b1, 8'h00, 1'b0, 1'b1);

        // Wrap-around with random occupancy.
        random_run(200);

        // Flush with a write pending, then refill and reset between edges.
        do_reset();
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'(8'h20 + i));
        step(1'b0, 1'b1, 8'h00);
        step(1'b1, 1'b0, 8'h77, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'(8'h30 + i));
        step(1'b0, 1'b0, 8'h00);
        do_reset();
        step(1'b0, 1'b0, 8'h00);

        // FWFT instance.
        mode = 1'b1;
        do_reset();
        step(1'b1, 1'b0, 8'h3C);
        step(1'b1, 1'b0, 8'h3D);
        step(1'b0, 1'b1, 8'h00);
        step(1'b0, 1'b1, 8'h00);
        step(1'b0, 1'b0, 8'h00);
        random_run(200);
        step(1'b0, 1'b0, 8'h00);

        repeat (3) @(negedge clk);
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
